// File: rtl/block_code_pkg.sv
// Shared definitions for the (20,A) block-code receive front end.
// Contents: default sizing constants, the sequencer state type, the soft
// symbol type and the 32-entry codeword permutation table (1-based entries).
package block_code_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int N_RX_DEF       = 20;
    localparam int N_EXT_DEF      = 32;
    localparam int MAX_A_DEF      = 13;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COLLECT   = 2'd1,
        S_STREAM    = 2'd2,
        S_WAIT_DONE = 2'd3
    } ctrl_state_t;

    typedef logic [DATA_WIDTH_DEF-1:0] sym_t;

    // Entry k names the 1-based extended-codeword position sent on beat k.
    // Positions above N_RX_DEF are zero-filled extension entries.
    localparam logic [7:0] PERM_A20 [0:N_EXT_DEF-1] = '{
        8'd1,  8'd14, 8'd27, 8'd8,  8'd21, 8'd2,  8'd15, 8'd28,
        8'd9,  8'd22, 8'd3,  8'd16, 8'd29, 8'd10, 8'd23, 8'd4,
        8'd17, 8'd30, 8'd11, 8'd24, 8'd5,  8'd18, 8'd31, 8'd12,
        8'd25, 8'd6,  8'd19, 8'd32, 8'd13, 8'd26, 8'd7,  8'd20
    };

endpackage

// File: rtl/block_code_frame_ctrl_if.sv
// Output stream of the frame sequencer towards the decoder.
// Signals: out_symbol (permuted symbol), out_valid, out_last (final beat),
// out_ready (decoder accepts). master = sequencer, slave = decoder.
interface block_code_frame_ctrl_if #(
    parameter int DATA_WIDTH = block_code_pkg::DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] out_symbol;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (output out_symbol, output out_valid, output out_last, input out_ready);
    modport slave  (input out_symbol, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/block_code_perm_rom.sv
// Combinational permutation lookup: beat index rd_idx -> 1-based codeword
// position p, taken from the shared package table.
// Ports: rd_idx (beat index), p (position 1..32).
module block_code_perm_rom
    import block_code_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       p
);

    // table lookup
    always_comb begin
        p = PERM_A20[rd_idx];
    end

endmodule

// File: rtl/block_code_frame_ctrl.sv
// Frame sequencer for the (20,A) block-code receiver. Captures a burst of
// N_RX soft symbols, validates length and code_length, then streams the
// zero-extended permuted N_EXT-beat codeword and waits for dec_done.
// Ports: clk, rst (async, active-high); rx_symbols/rx_symbols_valid/
// code_length (input frame); out_if (output stream, master side);
// dec_start/dec_code_length/dec_done (decoder control); busy, frame_err,
// rx_overrun (status pulses).
module block_code_frame_ctrl
    import block_code_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_RX       = N_RX_DEF,
    parameter int N_EXT      = N_EXT_DEF,
    parameter int MAX_A      = MAX_A_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        rx_symbols,
    input  logic                         rx_symbols_valid,
    input  logic [3:0]                   code_length,
    block_code_frame_ctrl_if.master      out_if,
    output logic                         dec_start,
    output logic [3:0]                   dec_code_length,
    input  logic                         dec_done,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         rx_overrun
);

    localparam int WR_W  = $clog2(N_RX + 2);
    localparam int RD_W  = $clog2(N_EXT);
    localparam int BUF_W = $clog2(N_RX);
    localparam logic [WR_W-1:0] WR_FULL = WR_W'(N_RX);
    localparam logic [WR_W-1:0] WR_SAT  = WR_W'(N_RX + 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(N_EXT - 1);

    ctrl_state_t            state_r, state_nx;
    logic [DATA_WIDTH-1:0]  sym_buf_r [N_RX];
    logic [WR_W-1:0]        wr_cnt_r;
    logic [RD_W-1:0]        rd_idx_r;
    logic                   ovf_r;
    logic                   rx_valid_d_r;
    logic [3:0]             a_r;
    logic [DATA_WIDTH-1:0]  out_symbol_r;
    logic                   out_valid_r, out_last_r;
    logic                   dec_start_r, busy_r, frame_err_r, rx_overrun_r;

    logic                   frame_end_s, frame_bad_s, load_s, last_acc_s;
    logic                   buf_we_s;
    logic [BUF_W-1:0]       buf_wa_s, buf_idx_s;
    logic [7:0]             p_s;
    logic [DATA_WIDTH-1:0]  beat_sym_s;

    block_code_perm_rom #(.IDX_W(RD_W)) u_rom (
        .rd_idx (rd_idx_r),
        .p      (p_s)
    );

    // frame-end detect, validity of the captured frame, output load enable
    always_comb begin
        frame_end_s = rx_valid_d_r && !rx_symbols_valid;
        frame_bad_s = (wr_cnt_r != WR_FULL) || ovf_r || (a_r == 4'd0) || (a_r > 4'(MAX_A));
        load_s      = !out_valid_r || out_if.out_ready;
        last_acc_s  = out_valid_r && out_last_r && out_if.out_ready;
    end

    // extension positions (p > N_RX) and a defensive p = 0 read as zero
    always_comb begin
        buf_idx_s  = BUF_W'(p_s - 8'd1);
        beat_sym_s = {DATA_WIDTH{1'b0}};
        if ((p_s >= 8'd1) && (p_s <= 8'(N_RX))) begin
            beat_sym_s = sym_buf_r[buf_idx_s];
        end else begin
            beat_sym_s = {DATA_WIDTH{1'b0}};
        end
    end

    // capture-buffer write strobe and address
    always_comb begin
        buf_we_s = 1'b0;
        buf_wa_s = {BUF_W{1'b0}};
        if ((state_r == S_IDLE) && rx_symbols_valid) begin
            buf_we_s = 1'b1;
        end else if ((state_r == S_COLLECT) && rx_symbols_valid && (wr_cnt_r < WR_FULL)) begin
            buf_we_s = 1'b1;
            buf_wa_s = BUF_W'(wr_cnt_r);
        end else begin
            buf_we_s = 1'b0;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (rx_symbols_valid) state_nx = S_COLLECT;
                else                  state_nx = S_IDLE;
            end
            S_COLLECT: begin
                if (frame_end_s) state_nx = frame_bad_s ? S_IDLE : S_STREAM;
                else             state_nx = S_COLLECT;
            end
            S_STREAM: begin
                if (last_acc_s) state_nx = S_WAIT_DONE;
                else            state_nx = S_STREAM;
            end
            S_WAIT_DONE: begin
                if (dec_done) state_nx = S_IDLE;
                else          state_nx = S_WAIT_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_nx;
    end

    // capture buffer; contents are deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (buf_we_s) sym_buf_r[buf_wa_s] <= rx_symbols;
    end

    // counters, flags and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r     <= {WR_W{1'b0}};
            rd_idx_r     <= {RD_W{1'b0}};
            ovf_r        <= 1'b0;
            rx_valid_d_r <= 1'b0;
            a_r          <= 4'd0;
            out_symbol_r <= {DATA_WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            dec_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_valid_d_r <= rx_symbols_valid;
            busy_r       <= (state_nx != S_IDLE);
            dec_start_r  <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_overrun_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (rx_symbols_valid) begin
                        wr_cnt_r <= WR_W'(1);
                        ovf_r    <= 1'b0;
                        a_r      <= code_length;
                    end
                end
                S_COLLECT: begin
                    if (rx_symbols_valid) begin
                        if (wr_cnt_r >= WR_FULL) ovf_r <= 1'b1;
                        if (wr_cnt_r != WR_SAT)  wr_cnt_r <= wr_cnt_r + WR_W'(1);
                    end else if (frame_end_s) begin
                        if (frame_bad_s) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            dec_start_r <= 1'b1;
                            rd_idx_r    <= {RD_W{1'b0}};
                        end
                    end
                end
                S_STREAM: begin
                    rx_overrun_r <= rx_symbols_valid;
                    if (load_s) begin
                        if (out_valid_r && out_last_r) begin
                            // final beat just accepted
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            out_symbol_r <= beat_sym_s;
                            out_valid_r  <= 1'b1;
                            out_last_r   <= (rd_idx_r == RD_LAST);
                            if (rd_idx_r != RD_LAST) rd_idx_r <= rd_idx_r + RD_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    rx_overrun_r <= rx_symbols_valid;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_symbol = out_symbol_r;
    assign out_if.out_valid  = out_valid_r;
    assign out_if.out_last   = out_last_r;
    assign dec_start         = dec_start_r;
    assign dec_code_length   = a_r;
    assign busy              = busy_r;
    assign frame_err         = frame_err_r;
    assign rx_overrun        = rx_overrun_r;

endmodule

// File: tb/tb_block_code_frame_ctrl.sv
// Scoreboard bench for block_code_frame_ctrl: stimulus pushes expected beats,
// a negedge monitor pops and compares on every accepted beat.
module tb_block_code_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rx_symbols = 4'd0;
    logic       rx_symbols_valid = 1'b0;
    logic [3:0] code_length = 4'd0;
    logic       dec_start, busy, frame_err, rx_overrun;
    logic [3:0] dec_code_length;
    logic       dec_done = 1'b0;

    block_code_frame_ctrl_if #(.DATA_WIDTH(4)) ifc ();

    block_code_frame_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rx_symbols       (rx_symbols),
        .rx_symbols_valid (rx_symbols_valid),
        .code_length      (code_length),
        .out_if           (ifc.master),
        .dec_start        (dec_start),
        .dec_code_length  (dec_code_length),
        .dec_done         (dec_done),
        .busy             (busy),
        .frame_err        (frame_err),
        .rx_overrun       (rx_overrun)
    );

    always #5 clk = ~clk;

    int perm_tab [32] = '{1, 14, 27, 8, 21, 2, 15, 28, 9, 22, 3, 16, 29, 10, 23, 4,
                          17, 30, 11, 24, 5, 18, 31, 12, 25, 6, 19, 32, 13, 26, 7, 20};

    typedef struct packed { logic last; logic [3:0] sym; } beat_t;
    beat_t exp_q [$];

    int n_checks = 0, n_fail = 0;
    int beat_cnt = 0, start_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
    int ready_mode = 0;
    int cyc = 0;
    logic [3:0] exp_a = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // cycle counter and out_ready pattern 1,0,0,1 in backpressure mode
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) ifc.out_ready = 1'b1;
            else                 ifc.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end
    end

    // monitor: pop/compare accepted beats, check stall stability, count pulses
    initial begin
        logic       prev_stall;
        logic [3:0] prev_sym;
        logic       prev_last;
        beat_t      e;
        prev_stall = 1'b0;
        prev_sym   = 4'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(ifc.out_valid), 32'd1);
                    check("stall_sym", 32'(ifc.out_symbol), 32'(prev_sym));
                    check("stall_last", 32'(ifc.out_last), 32'(prev_last));
                end
                if (dec_start) begin
                    start_cnt++;
                    check("dec_code_length", 32'(dec_code_length), 32'(exp_a));
                end
                if (frame_err)  ferr_cnt++;
                if (rx_overrun) ovr_cnt++;
                if (ifc.out_valid && ifc.out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_sym", 32'(ifc.out_symbol), 32'(e.sym));
                        check("beat_last", 32'(ifc.out_last), 32'(e.last));
                    end
                    beat_cnt++;
                end
                prev_stall = ifc.out_valid && !ifc.out_ready;
                prev_sym   = ifc.out_symbol;
                prev_last  = ifc.out_last;
            end
        end
    end

    // expected codeword for a frame whose symbol i is base+i+1 (4-bit wrap)
    task automatic push_frame(input logic [3:0] base);
        beat_t b;
        for (int k = 0; k < 32; k++) begin
            b.last = (k == 31);
            b.sym  = (perm_tab[k] <= 20) ? base + 4'(perm_tab[k]) : 4'd0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_burst(input int n, input logic [3:0] a, input logic [3:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_symbols_valid = 1'b1;
            rx_symbols       = base + 4'(i + 1);
            code_length      = a;
        end
        @(posedge clk);
        #1;
        rx_symbols_valid = 1'b0;
        rx_symbols       = 4'd0;
    endtask

    task automatic finish_codeword(input string tag);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && busy && !ifc.out_valid) && t < 400) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 400) fail_now({tag, "_stream_timeout"});
        check({tag, "_beat_count"}, 32'(beat_cnt), 32'd32);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_busy_hold"}, 32'(busy), 32'd1);
        dec_done = 1'b1;
        @(posedge clk);
        #1;
        dec_done = 1'b0;
        #1;
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    int err_n [4] = '{19, 22, 20, 20};
    logic [3:0] err_a [4] = '{4'd11, 4'd11, 4'd0, 4'd14};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dec_start", 32'(dec_start), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_code_len", 32'(dec_code_length), 32'd0);
        rst = 1'b0;

        // nominal frame
        beat_cnt = 0; start_cnt = 0; exp_a = 4'd11;
        push_frame(4'd0);
        send_burst(20, 4'd11, 4'd0);
        @(posedge clk);
        #2;
        check("nom_dec_start", 32'(dec_start), 32'd1);
        check("nom_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        check("nom_start_pulse", 32'(dec_start), 32'd0);
        check("nom_first_valid", 32'(ifc.out_valid), 32'd1);
        finish_codeword("nom");
        check("nom_start_cnt", 32'(start_cnt), 32'd1);

        // backpressure
        ready_mode = 1; beat_cnt = 0; start_cnt = 0;
        push_frame(4'd0);
        send_burst(20, 4'd11, 4'd0);
        finish_codeword("bp");
        check("bp_start_cnt", 32'(start_cnt), 32'd1);
        ready_mode = 0;

        // length and code_length errors
        for (int j = 0; j < 4; j++) begin
            ferr_cnt = 0; start_cnt = 0;
            repeat (2) @(posedge clk);
            send_burst(err_n[j], err_a[j], 4'd3);
            repeat (3) @(posedge clk);
            #2;
            check("err_frame_err_cnt", 32'(ferr_cnt), 32'd1);
            check("err_no_start", 32'(start_cnt), 32'd0);
            check("err_idle", 32'(busy), 32'd0);
        end

        // overrun during STREAM
        beat_cnt = 0; ovr_cnt = 0; ferr_cnt = 0; exp_a = 4'd11;
        push_frame(4'd0);
        send_burst(20, 4'd11, 4'd0);
        repeat (2) @(posedge clk);
        send_burst(5, 4'd2, 4'hA);
        repeat (2) @(posedge clk);
        #2;
        check("ovr_count", 32'(ovr_cnt), 32'd5);
        finish_codeword("ovr");
        check("ovr_no_frame_err", 32'(ferr_cnt), 32'd0);
        beat_cnt = 0; exp_a = 4'd7;
        push_frame(4'd5);
        send_burst(20, 4'd7, 4'd5);
        finish_codeword("ovr_next");

        // reset mid-stream
        beat_cnt = 0; exp_a = 4'd11;
        push_frame(4'd0);
        send_burst(20, 4'd11, 4'd0);
        begin
            int t;
            t = 0;
            while (beat_cnt < 10 && t < 200) begin
                @(posedge clk);
                t++;
            end
            if (t >= 200) fail_now("rst_wait_beat10");
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dec_start", 32'(dec_start), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        beat_cnt = 0; exp_a = 4'd13;
        push_frame(4'd9);
        send_burst(20, 4'd13, 4'd9);
        finish_codeword("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_code_frame_ctrl.md
Name: block_code_frame_ctrl

Overview:
- Front-end sequencer for the (20,A) block-code receive path.
- Captures one frame of 20 soft symbols and validates frame length and code_length.
- Streams the 32-entry zero-extended, permuted codeword to the downstream decoder over a valid/ready handshake, then holds off new frames until the decoder reports done.
- Owns the permutation ROM and the capture buffer.

Parameters:
- DATA_WIDTH, 4, soft-symbol width in bits
- N_RX, 20, received symbols per frame
- N_EXT, 32, extended codeword length; must be ≥ N_RX
- MAX_A, 13, largest legal code_length

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_symbols  in  DATA_WIDTH  input soft symbol
- rx_symbols_valid  in  1  symbol qualifier; a frame is one contiguous valid burst
- code_length  in  4  information length A; sampled with the first symbol of a frame
- out_symbol  out  DATA_WIDTH  permuted, extended symbol
- out_valid  out  1  out_symbol is valid
- out_last  out  1  marks beat 31
- out_ready  in  1  downstream accepts the beat
- dec_start  out  1  one-cycle pulse marking the start of a codeword
- dec_code_length  out  4  latched A, stable from dec_start until return to IDLE
- dec_done  in  1  decoder finished the current codeword
- busy  out  1  state != IDLE
- frame_err  out  1  one-cycle pulse: bad frame discarded
- rx_overrun  out  1  one-cycle pulse: symbol dropped because the block was not accepting

Behaviour:
- Reset is asynchronous. All outputs go to 0 immediately; FSM goes to IDLE; counters clear. The buffer is not cleared.
- Frame end is detected when rx_symbols_valid is low in a cycle where it was high the previous cycle (falling edge of the burst).
- FSM states are IDLE, COLLECT, STREAM and WAIT_DONE.
- IDLE: a valid symbol writes buf[0], sets wr_cnt=1, latches code_length, and moves to COLLECT.
- COLLECT: each valid symbol writes buf[wr_cnt] while wr_cnt < N_RX, then wr_cnt increments, saturating at N_RX+1.
  - A symbol arriving at wr_cnt ≥ N_RX is dropped and sets the sticky ovf flag.
- At frame end:
  - Error if wr_cnt != N_RX, or ovf is set, or the latched A is 0, or A > MAX_A. On error: frame_err pulses, then the FSM returns to IDLE.
  - Otherwise the FSM enters STREAM, dec_start pulses for one cycle, and rd_idx is set to 0.
- STREAM:
  - p = PERM[rd_idx], with values 1..N_EXT.
  - out_symbol = buf[p-1] when 1 ≤ p ≤ N_RX; otherwise 0 (extension entries, and p=0 treated defensively).
  - The output register loads when !out_valid || out_ready.
  - While stalled, out_symbol, out_valid and out_last hold stable.
  - rd_idx covers 0..N_EXT-1 inclusive.
  - out_last = 1 on the rd_idx = N_EXT-1 beat.
  - When the last beat is accepted, out_valid drops in the next cycle and the FSM goes to WAIT_DONE.
- WAIT_DONE: dec_done moves the FSM to IDLE. dec_done is ignored in every other state.
- Latency: frame end is sampled at edge E; out_valid is high after edge E+1. With out_ready tied to 1, the 32 beats occupy cycles E+1..E+32 and busy drops one cycle after dec_done.
- Symbols valid in STREAM or WAIT_DONE are dropped. rx_overrun pulses once per dropped symbol and no state changes.
- A frame may restart in the IDLE cycle that immediately follows dec_done. Back-to-back bursts need ≥1 invalid cycle between them.
- Widths:
  - wr_cnt is $clog2(N_RX+2) bits.
  - rd_idx is $clog2(N_EXT) bits; rd_idx does not wrap past N_EXT-1, the FSM exits first.

Decomposition:
- Package block_code_pkg holds:
  - constants N_RX_DEF=20, N_EXT_DEF=32, MAX_A_DEF=13;
  - the state enum typedef ctrl_state_t;
  - typedef sym_t as logic [DATA_WIDTH-1:0] (parameterised via the package default);
  - the 32×8 permutation constant array PERM_A20.
- Sub-module block_code_perm_rom: combinational lookup of rd_idx → p, sourced from the package constant.

Test Plan:
- Nominal frame: 20 symbols, value i+1 for symbol i (4-bit wrap), A=11, out_ready=1 → dec_start one cycle after the frame end; 32 beats, each equal to buf[PERM[k]-1] or 0 when PERM[k] > 20; out_last on beat 31; dec_code_length=11; busy stays high until dec_done.
- Backpressure: same frame with out_ready toggling 1,0,0,1 repeating → identical 32-beat sequence; out_symbol and out_valid stable during every stalled cycle; no beat lost or duplicated.
- Length errors → frame_err pulses once, no dec_start, FSM back in IDLE:
  - 19-symbol burst;
  - 22-symbol burst.
- Illegal A → frame_err, no dec_start:
  - 20 symbols with A=0;
  - 20 symbols with A=14.
- Overrun: second burst of 5 symbols during STREAM → rx_overrun pulses 5 times; the streamed codeword is unchanged; the next frame after dec_done decodes correctly.
- Reset mid-stream: assert rst at beat 10 → out_valid, busy and dec_start drop to 0 immediately; after release, a new nominal frame streams all 32 beats correctly.
